// File: rtl/scr1_arb_pkg.sv
// Shared types and memory-interface encodings for the SCR1 instruction/data memory arbiter.
package scr1_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } type_scr1_arb_fsm_e;

  typedef enum logic {
    IMEM = 1'b0,
    DMEM = 1'b1
  } type_scr1_arb_src_e;

  localparam logic       SCR1_MEM_CMD_RD      = 1'b0;
  localparam logic [1:0] SCR1_MEM_WIDTH_WORD  = 2'b10;
  localparam logic [1:0] SCR1_MEM_RESP_NOTRDY = 2'b00;
  localparam logic [1:0] SCR1_MEM_RESP_RDY_OK = 2'b01;
  localparam logic [1:0] SCR1_MEM_RESP_RDY_ER = 2'b10;

  function automatic type_scr1_arb_src_e scr1_arb_other(input type_scr1_arb_src_e src);
    return (src == IMEM) ? DMEM : IMEM;
  endfunction

endpackage

// File: rtl/scr1_arb_rr2.sv
// Two-way grant generator: round-robin or fixed data-port priority, history updated only on accept.
module scr1_arb_rr2
  import scr1_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_imem,
  input  logic               req_dmem,
  input  logic               accept,
  output type_scr1_arb_src_e grant
);

  type_scr1_arb_src_e last_grant;

  always_comb begin
    grant = IMEM;
    if (req_dmem && !req_imem) begin
      grant = DMEM;
    end else if (req_dmem && req_imem) begin
      grant = FIXED_PRIO ? DMEM : scr1_arb_other(last_grant);
    end
  end

  // Reset history to DMEM so the instruction side wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= DMEM;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/scr1_mem_arbiter.sv
// Shares one SCR1 memory port between the instruction and data ports, one transaction outstanding,
// zero-latency request mux and response routing to the transaction owner.
module scr1_mem_arbiter
  import scr1_arb_pkg::*;
#(
  parameter int SCR1_ARB_FIXED_PRIO = 0,
  parameter int SCR1_ARB_AWIDTH     = 32,
  parameter int SCR1_ARB_DWIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       imem_req,
  output logic                       imem_req_ack,
  input  logic [SCR1_ARB_AWIDTH-1:0] imem_addr,
  output logic [SCR1_ARB_DWIDTH-1:0] imem_rdata,
  output logic [1:0]                 imem_resp,
  input  logic                       dmem_req,
  output logic                       dmem_req_ack,
  input  logic                       dmem_cmd,
  input  logic [1:0]                 dmem_width,
  input  logic [SCR1_ARB_AWIDTH-1:0] dmem_addr,
  input  logic [SCR1_ARB_DWIDTH-1:0] dmem_wdata,
  output logic [SCR1_ARB_DWIDTH-1:0] dmem_rdata,
  output logic [1:0]                 dmem_resp,
  output logic                       mem_req,
  input  logic                       mem_req_ack,
  output logic                       mem_cmd,
  output logic [1:0]                 mem_width,
  output logic [SCR1_ARB_AWIDTH-1:0] mem_addr,
  output logic [SCR1_ARB_DWIDTH-1:0] mem_wdata,
  input  logic [SCR1_ARB_DWIDTH-1:0] mem_rdata,
  input  logic [1:0]                 mem_resp
);

  type_scr1_arb_fsm_e fsm;
  type_scr1_arb_src_e owner;
  type_scr1_arb_src_e grant;
  logic               open;
  logic               accept;
  logic               stray_ok;

  scr1_arb_rr2 #(
    .FIXED_PRIO (SCR1_ARB_FIXED_PRIO != 0)
  ) u_rr2 (
    .clk      (clk),
    .rst      (rst),
    .req_imem (imem_req),
    .req_dmem (dmem_req),
    .accept   (accept),
    .grant    (grant)
  );

  always_comb begin
    open   = !rst && ((fsm == IDLE) || (mem_resp == SCR1_MEM_RESP_RDY_OK));
    accept = open && (imem_req || dmem_req) && mem_req_ack;
  end

  always_comb begin
    mem_req      = open && (imem_req || dmem_req);
    imem_req_ack = accept && (grant == IMEM);
    dmem_req_ack = accept && (grant == DMEM);
    if (grant == DMEM) begin
      mem_cmd   = dmem_cmd;
      mem_width = dmem_width;
      mem_addr  = dmem_addr;
      mem_wdata = dmem_wdata;
    end else begin
      mem_cmd   = SCR1_MEM_CMD_RD;
      mem_width = SCR1_MEM_WIDTH_WORD;
      mem_addr  = imem_addr;
      mem_wdata = '0;
    end
  end

  always_comb begin
    imem_resp  = SCR1_MEM_RESP_NOTRDY;
    imem_rdata = '0;
    dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    dmem_rdata = '0;
    if (!rst && (fsm == DATA)) begin
      if (owner == IMEM) begin
        imem_resp  = mem_resp;
        imem_rdata = mem_rdata;
      end else begin
        dmem_resp  = mem_resp;
        dmem_rdata = mem_rdata;
      end
    end
  end

  // A completing response reopens the window, so a new accept keeps DATA with no idle cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm   <= IDLE;
      owner <= IMEM;
    end else begin
      case (fsm)
        IDLE: begin
          if (accept) begin
            fsm   <= DATA;
            owner <= grant;
          end
        end
        DATA: begin
          if (mem_resp == SCR1_MEM_RESP_RDY_OK) begin
            if (accept) begin
              owner <= grant;
            end else begin
              fsm <= IDLE;
            end
          end else if (mem_resp != SCR1_MEM_RESP_NOTRDY) begin
            fsm <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // A reset during DATA orphans one response; tolerate that single stray response in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      stray_ok <= stray_ok || (fsm == DATA);
    end else if ((fsm == IDLE) && (mem_resp != SCR1_MEM_RESP_NOTRDY)) begin
      stray_ok <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((mem_resp == SCR1_MEM_RESP_NOTRDY) || (fsm == DATA) || stray_ok)
        else $error("scr1_mem_arbiter: mem_resp active while no transaction is outstanding");
      if (imem_req) begin
        assert (!$isunknown(imem_addr))
          else $error("scr1_mem_arbiter: unknown imem request fields");
      end
      if (dmem_req) begin
        assert (!$isunknown({dmem_cmd, dmem_width, dmem_addr, dmem_wdata}))
          else $error("scr1_mem_arbiter: unknown dmem request fields");
      end
    end
  end

endmodule

// File: tb/tb_scr1_mem_arbiter.sv
// Directed bench for scr1_mem_arbiter: round-robin instance fully checked, fixed-priority instance
// checked on the contended phase; both see identical stimulus.
module tb_scr1_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        dmem_req;
  logic        dmem_cmd;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        mem_req_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_resp;

  logic        imem_req_ack, dmem_req_ack, mem_req, mem_cmd;
  logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic [1:0]  imem_resp, dmem_resp, mem_width;

  logic        f_imem_req_ack, f_dmem_req_ack, f_mem_req, f_mem_cmd;
  logic [31:0] f_imem_rdata, f_dmem_rdata, f_mem_addr, f_mem_wdata;
  logic [1:0]  f_imem_resp, f_dmem_resp, f_mem_width;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scr1_mem_arbiter #(
    .SCR1_ARB_FIXED_PRIO (0),
    .SCR1_ARB_AWIDTH     (32),
    .SCR1_ARB_DWIDTH     (32)
  ) dut_rr (
    .clk (clk), .rst (rst),
    .imem_req (imem_req), .imem_req_ack (imem_req_ack), .imem_addr (imem_addr),
    .imem_rdata (imem_rdata), .imem_resp (imem_resp),
    .dmem_req (dmem_req), .dmem_req_ack (dmem_req_ack), .dmem_cmd (dmem_cmd),
    .dmem_width (dmem_width), .dmem_addr (dmem_addr), .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata), .dmem_resp (dmem_resp),
    .mem_req (mem_req), .mem_req_ack (mem_req_ack), .mem_cmd (mem_cmd),
    .mem_width (mem_width), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata), .mem_resp (mem_resp)
  );

  scr1_mem_arbiter #(
    .SCR1_ARB_FIXED_PRIO (1),
    .SCR1_ARB_AWIDTH     (32),
    .SCR1_ARB_DWIDTH     (32)
  ) dut_fp (
    .clk (clk), .rst (rst),
    .imem_req (imem_req), .imem_req_ack (f_imem_req_ack), .imem_addr (imem_addr),
    .imem_rdata (f_imem_rdata), .imem_resp (f_imem_resp),
    .dmem_req (dmem_req), .dmem_req_ack (f_dmem_req_ack), .dmem_cmd (dmem_cmd),
    .dmem_width (dmem_width), .dmem_addr (dmem_addr), .dmem_wdata (dmem_wdata),
    .dmem_rdata (f_dmem_rdata), .dmem_resp (f_dmem_resp),
    .mem_req (f_mem_req), .mem_req_ack (mem_req_ack), .mem_cmd (f_mem_cmd),
    .mem_width (f_mem_width), .mem_addr (f_mem_addr), .mem_wdata (f_mem_wdata),
    .mem_rdata (mem_rdata), .mem_resp (mem_resp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_addr;
    rst = 1'b1; imem_req = 1'b0; imem_addr = '0; dmem_req = 1'b0; dmem_cmd = 1'b0;
    dmem_width = 2'd0; dmem_addr = '0; dmem_wdata = '0; mem_req_ack = 1'b0;
    mem_rdata = '0; mem_resp = 2'd0;
    nxt; nxt;

    // Outputs gated while reset is held, even with requests and a response present
    imem_req = 1'b1; dmem_req = 1'b1; mem_req_ack = 1'b1; mem_resp = 2'd1;
    settle;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_imem_ack", imem_req_ack, 0);
    chk("rst_dmem_ack", dmem_req_ack, 0);
    chk("rst_imem_resp", imem_resp, 0);
    chk("rst_dmem_resp", dmem_resp, 0);

    nxt;
    rst = 1'b0; imem_req = 1'b0; dmem_req = 1'b0; mem_req_ack = 1'b0; mem_resp = 2'd0;
    settle;
    chk("idle_mem_req", mem_req, 0);

    // Instruction-only read, response after two NOTRDY cycles
    nxt;
    imem_req = 1'b1; imem_addr = 32'h100; mem_req_ack = 1'b1;
    settle;
    chk("t1_mem_req", mem_req, 1);
    chk("t1_cmd", mem_cmd, 0);
    chk("t1_width", mem_width, 2);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_wdata", mem_wdata, 0);
    chk("t1_imem_ack", imem_req_ack, 1);
    chk("t1_dmem_ack", dmem_req_ack, 0);
    nxt;
    settle;
    chk("t1_closed_req", mem_req, 0);
    chk("t1_closed_ack", imem_req_ack, 0);
    chk("t1_notrdy1", imem_resp, 0);
    chk("t1_dresp1", dmem_resp, 0);
    nxt;
    imem_req = 1'b0;
    settle;
    chk("t1_notrdy2", imem_resp, 0);
    chk("t1_dresp2", dmem_resp, 0);
    nxt;
    mem_resp = 2'd1; mem_rdata = 32'hCAFE0001;
    settle;
    chk("t1_imem_resp", imem_resp, 1);
    chk("t1_imem_rdata", imem_rdata, 32'hCAFE0001);
    chk("t1_dmem_resp", dmem_resp, 0);
    chk("t1_dmem_rdata", dmem_rdata, 0);
    nxt;
    mem_resp = 2'd0; mem_rdata = '0;
    settle;
    chk("t1_back_idle", imem_resp, 0);

    // Reset pulse so the contended phase starts with IMEM winning the tie
    nxt;
    rst = 1'b1;
    settle;
    nxt;
    rst = 1'b0; imem_req = 1'b1; imem_addr = 32'h200;
    dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'd2; dmem_addr = 32'h3000;
    dmem_wdata = 32'h11111111; mem_req_ack = 1'b1;
    settle;
    chk("rr0_mem_req", mem_req, 1);
    chk("rr0_addr", mem_addr, 32'h200);
    chk("rr0_imem_ack", imem_req_ack, 1);
    chk("rr0_dmem_ack", dmem_req_ack, 0);
    chk("fp0_addr", f_mem_addr, 32'h3000);
    chk("fp0_imem_ack", f_imem_req_ack, 0);
    chk("fp0_dmem_ack", f_dmem_req_ack, 1);

    for (int k = 1; k <= 3; k++) begin
      nxt;
      mem_resp = 2'd1; mem_rdata = 32'hA0000000 + 32'(k);
      settle;
      exp_addr = (k % 2 == 1) ? 32'h3000 : 32'h200;
      chk("rr_no_bubble", mem_req, 1);
      chk("rr_addr", mem_addr, exp_addr);
      chk("rr_imem_ack", imem_req_ack, (k % 2 == 1) ? 0 : 1);
      chk("rr_dmem_ack", dmem_req_ack, (k % 2 == 1) ? 1 : 0);
      chk("rr_imem_resp", imem_resp, (k % 2 == 1) ? 1 : 0);
      chk("rr_dmem_resp", dmem_resp, (k % 2 == 1) ? 0 : 1);
      chk("rr_rdata", (k % 2 == 1) ? imem_rdata : dmem_rdata, 32'hA0000000 + 32'(k));
      chk("fp_imem_ack", f_imem_req_ack, 0);
      chk("fp_dmem_ack", f_dmem_req_ack, 1);
      chk("fp_dmem_resp", f_dmem_resp, 1);
      chk("fp_addr", f_mem_addr, 32'h3000);
    end
    nxt;
    imem_req = 1'b0; dmem_req = 1'b0; mem_rdata = 32'hA0000004;
    settle;
    chk("rr_last_dresp", dmem_resp, 1);
    chk("rr_last_rdata", dmem_rdata, 32'hA0000004);
    chk("rr_last_req", mem_req, 0);
    chk("fp_last_dresp", f_dmem_resp, 1);
    nxt;
    mem_resp = 2'd0; mem_rdata = '0;
    settle;
    chk("rr_idle_iresp", imem_resp, 0);
    chk("rr_idle_dresp", dmem_resp, 0);

    // Data byte write ending in RDY_ER: window closed that cycle, IMEM accepted next
    nxt;
    dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_width = 2'd0; dmem_addr = 32'h2000;
    dmem_wdata = 32'hDEADBEEF;
    settle;
    chk("er_cmd", mem_cmd, 1);
    chk("er_width", mem_width, 0);
    chk("er_addr", mem_addr, 32'h2000);
    chk("er_wdata", mem_wdata, 32'hDEADBEEF);
    chk("er_dmem_ack", dmem_req_ack, 1);
    nxt;
    dmem_req = 1'b0; imem_req = 1'b1; imem_addr = 32'h300; mem_resp = 2'd2;
    settle;
    chk("er_dmem_resp", dmem_resp, 2);
    chk("er_imem_resp", imem_resp, 0);
    chk("er_closed_req", mem_req, 0);
    chk("er_closed_iack", imem_req_ack, 0);
    nxt;
    mem_resp = 2'd0;
    settle;
    chk("er_next_iack", imem_req_ack, 1);
    chk("er_next_addr", mem_addr, 32'h300);
    chk("er_next_cmd", mem_cmd, 0);
    chk("er_next_width", mem_width, 2);
    nxt;
    imem_req = 1'b0; mem_resp = 2'd1; mem_rdata = 32'h000055AA;
    settle;
    chk("er_ifetch_resp", imem_resp, 1);
    chk("er_ifetch_rdata", imem_rdata, 32'h000055AA);

    // Reset while a transaction is outstanding; the late response must be dropped
    nxt;
    mem_resp = 2'd0; mem_rdata = '0; imem_req = 1'b1; imem_addr = 32'h400;
    settle;
    chk("rs_accept", imem_req_ack, 1);
    nxt;
    rst = 1'b1; imem_req = 1'b0;
    settle;
    chk("rs_hold_req", mem_req, 0);
    chk("rs_hold_iresp", imem_resp, 0);
    nxt;
    rst = 1'b0; mem_resp = 2'd1; mem_rdata = 32'hBAD0BAD0;
    settle;
    chk("rs_late_iresp", imem_resp, 0);
    chk("rs_late_dresp", dmem_resp, 0);
    chk("rs_late_irdata", imem_rdata, 0);
    chk("rs_late_drdata", dmem_rdata, 0);
    nxt;
    mem_resp = 2'd0; mem_rdata = '0; imem_req = 1'b1; dmem_req = 1'b1;
    dmem_cmd = 1'b0; dmem_width = 2'd2; dmem_addr = 32'h3000;
    settle;
    chk("rs_tie_iack", imem_req_ack, 1);
    chk("rs_tie_dack", dmem_req_ack, 0);
    chk("rs_tie_addr", mem_addr, 32'h400);
    nxt;
    imem_req = 1'b0; dmem_req = 1'b0; mem_resp = 2'd1; mem_rdata = 32'h0000C0DE;
    settle;
    chk("rs_tie_iresp", imem_resp, 1);

    // Data request held without acknowledge: fields stable, no ack, no state change
    nxt;
    mem_resp = 2'd0; mem_rdata = '0; mem_req_ack = 1'b0;
    dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_width = 2'd1; dmem_addr = 32'h4004;
    dmem_wdata = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      settle;
      chk("st_mem_req", mem_req, 1);
      chk("st_cmd", mem_cmd, 1);
      chk("st_width", mem_width, 1);
      chk("st_addr", mem_addr, 32'h4004);
      chk("st_wdata", mem_wdata, 32'h12345678);
      chk("st_dack", dmem_req_ack, 0);
      chk("st_dresp", dmem_resp, 0);
      nxt;
    end
    mem_req_ack = 1'b1;
    settle;
    chk("st_late_dack", dmem_req_ack, 1);
    nxt;
    dmem_req = 1'b0; mem_resp = 2'd1; mem_rdata = 32'h0;
    settle;
    chk("st_dresp_ok", dmem_resp, 1);
    nxt;
    mem_resp = 2'd0;
    settle;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scr1_mem_arbiter.md
Name: scr1_mem_arbiter

Overview:
- Shares one SCR1 memory port (req/req_ack/cmd/addr/wdata/rdata/resp protocol) between the core instruction port (read-only) and the core data port.
- Sits between the core and the IMEM/DMEM routers, so both paths can reach a single-ported TCM or a single AHB/AXI bridge.
- Tracks one outstanding transaction and routes its response to the owner.
- Grants round-robin by default, or with fixed priority.

Parameters:
SCR1_ARB_FIXED_PRIO, 0, 1 = fixed priority to the data port; 0 = round-robin
SCR1_ARB_AWIDTH, 32, address width
SCR1_ARB_DWIDTH, 32, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_req  in  1  instruction request
imem_req_ack  out  1  instruction request accepted
imem_addr  in  AWIDTH  instruction address
imem_rdata  out  DWIDTH  instruction read data
imem_resp  out  2  instruction response (NOTRDY/RDY_OK/RDY_ER)
dmem_req  in  1  data request
dmem_req_ack  out  1  data request accepted
dmem_cmd  in  1  RD=0 / WR=1
dmem_width  in  2  BYTE/HWORD/WORD
dmem_addr  in  AWIDTH  data address
dmem_wdata  in  DWIDTH  write data
dmem_rdata  out  DWIDTH  data read data
dmem_resp  out  2  data response
mem_req  out  1  shared port request
mem_req_ack  in  1  shared port accepted
mem_cmd  out  1  command to shared port
mem_width  out  2  width to shared port
mem_addr  out  AWIDTH  address
mem_wdata  out  DWIDTH  write data
mem_rdata  in  DWIDTH  read data
mem_resp  in  2  response from shared port

Behaviour:
- Reset is synchronous: on the clk edge where rst=1, fsm=IDLE, owner=IMEM, last_grant=DMEM (the IMEM requester wins the first tie).
- While rst=1: all req_ack=0, mem_req=0, both resp=NOTRDY.
- State machine:
  - IDLE: no transaction outstanding.
  - DATA: one transaction outstanding. `owner` holds its source.
- Accept window ("open"): fsm==IDLE, or fsm==DATA with mem_resp==RDY_OK.
- Grant selection, combinational, evaluated only in the open window:
  - Only one requester active: that requester is granted.
  - Both active, fixed priority: DMEM wins.
  - Both active, round-robin: the requester opposite to last_grant wins.
- Request mux:
  - mem_req = open & (imem_req | dmem_req).
  - cmd/width/addr/wdata come from the granted requester.
  - IMEM grant forces cmd=RD, width=WORD, wdata=0.
- Acknowledge: granted_req_ack = mem_req_ack & open. The non-granted requester's ack is 0.
- Transitions:
  - IDLE→DATA on mem_req & mem_req_ack. Latch owner=grant and last_grant=grant.
  - DATA with mem_resp==NOTRDY: hold.
  - DATA with mem_resp==RDY_OK: if a new mem_req & mem_req_ack occurs, stay in DATA with the new owner (back-to-back, zero bubble). Otherwise go to IDLE.
  - DATA with mem_resp==RDY_ER: go to IDLE. No acceptance in the same cycle (window closed).
- Response routing:
  - Owner's resp = mem_resp and rdata = mem_rdata while fsm==DATA.
  - The other side gets resp=NOTRDY and rdata=0.
  - In IDLE, both resp=NOTRDY.
- Latency: zero-cycle combinational path from request to mem port and from mem_resp to the owner. No added pipeline stage.
- Starvation bound (round-robin): a continuously requesting port is granted within 2 accepts.
- Fixed-priority mode may starve IMEM by design.
- A request deasserted before ack is legal. The grant is re-evaluated every cycle and last_grant changes only on accept.
- Reset mid-transaction: the outstanding response is dropped. A late mem_resp arriving after reset is ignored because fsm==IDLE.
- Simulation assertions: mem_resp != NOTRDY only when fsm==DATA; no X on grant inputs when a req is high.

Decomposition:
- Shared package scr1_arb_pkg:
  - enum type_scr1_arb_fsm_e {IDLE, DATA}
  - enum type_scr1_arb_src_e {IMEM, DMEM}
- Reuse SCR1_MEM_CMD_*, SCR1_MEM_WIDTH_* and SCR1_MEM_RESP_* from scr1_memif.svh.
- One natural sub-module: scr1_arb_rr2, a 2-way round-robin/fixed-priority grant generator with last_grant register and update-on-accept input.

Test Plan:
- Only imem_req=1, addr=0x100, mem_req_ack=1, resp RDY_OK after 2 NOTRDY cycles -> mem_cmd=RD, mem_width=WORD, imem_resp=RDY_OK with rdata=mem_rdata on cycle 3, dmem_resp NOTRDY throughout.
- Both requesting continuously, RR mode, mem_req_ack=1, 1-cycle responses -> grant sequence IMEM, DMEM, IMEM, DMEM with no idle cycle between transactions.
- Same stimulus with SCR1_ARB_FIXED_PRIO=1 -> DMEM granted every accept; imem_req_ack stays 0.
- DMEM write 0xDEADBEEF to 0x2000, width=BYTE, mem_resp=RDY_ER -> dmem_resp=RDY_ER; no accept in that cycle even with imem_req=1; IMEM accepted the next cycle.
- Assert rst while in DATA, then mem_resp=RDY_OK after rst drops -> both resp stay NOTRDY; next IMEM request wins a tie.
- mem_req_ack=0 for 5 cycles with dmem_req held -> mem_req=1 with stable dmem fields; dmem_req_ack=0; fsm stays IDLE.
